// File: rtl/ysyx_040066_bpu_nxtpc.sv
// Next-PC unit: owns the fetch PC, predicts via a direct-mapped BTB with 2-bit
// counters, resolves the real next PC in EX and redirects on mispredict.
module ysyx_040066_bpu_nxtpc #(
    parameter int                XLEN        = 64,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0]   RESET_PC    = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_ready,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic [XLEN-1:0] ex_busA,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_zero,
    input  logic            ex_result0,
    input  logic [2:0]      ex_branch,
    output logic            is_jmp,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    // The carried prediction bit adds nothing once the full target is compared.
    logic unused_pred_taken;
    assign unused_pred_taken = ex_pred_taken;

    logic [IDX-1:0]  lk_idx;
    logic            lk_hit;
    logic [XLEN-1:0] pc_plus4;

    assign lk_idx      = pc[IDX+1:2];
    assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc[XLEN-1:IDX+2]);
    assign pc_plus4    = pc + XLEN'(4);
    assign pred_taken  = lk_hit & btb_ctr[lk_idx][1];
    assign pred_target = pred_taken ? btb_target[lk_idx] : pc_plus4;

    logic            taken;
    logic [XLEN-1:0] actual_next;

    always_comb begin
        taken = 1'b0;
        unique case (ex_branch)
            3'b000:  taken = 1'b0;
            3'b001:  taken = 1'b1;
            3'b010:  taken = 1'b1;
            3'b011:  taken = 1'b1;
            3'b100:  taken = ex_zero;
            3'b101:  taken = ~ex_zero;
            3'b110:  taken = ex_result0;
            3'b111:  taken = ex_zero | ~ex_result0;
            default: taken = 1'b0;
        endcase
        actual_next = ((ex_branch == 3'b010) ? ex_busA : ex_pc) + (taken ? ex_imm : XLEN'(4));
        if (ex_branch == 3'b010) actual_next[0] = 1'b0;
    end

    assign is_jmp      = ex_valid & taken;
    assign redirect    = ex_valid & (actual_next != ex_pred_target);
    assign redirect_pc = actual_next;

    logic            upd;
    logic            up_jump;
    logic            up_hit;
    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] up_tag;
    logic [1:0]      ctr_cur;
    logic [1:0]      ctr_nxt;
    logic            ctr_we;
    logic            tgt_we;
    logic            alloc;

    assign upd     = ex_valid & (ex_branch != 3'b000);
    assign up_jump = ex_branch inside {3'b001, 3'b010, 3'b011};
    assign up_idx  = ex_pc[IDX+1:2];
    assign up_tag  = ex_pc[XLEN-1:IDX+2];
    assign up_hit  = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    assign ctr_cur = btb_ctr[up_idx];

    always_comb begin
        ctr_nxt = ctr_cur;
        ctr_we  = 1'b0;
        tgt_we  = 1'b0;
        alloc   = 1'b0;
        if (upd) begin
            if (up_hit) begin
                ctr_we = 1'b1;
                if (up_jump) begin
                    ctr_nxt = 2'd3;
                    tgt_we  = 1'b1;
                end else if (taken) begin
                    ctr_nxt = (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
                    tgt_we  = 1'b1;
                end else begin
                    ctr_nxt = (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;
                end
            end else if (taken) begin
                alloc   = 1'b1;
                ctr_we  = 1'b1;
                tgt_we  = 1'b1;
                ctr_nxt = up_jump ? 2'd3 : 2'd2;
            end
        end
    end

    // Only valid bits and counters need a reset; tags and targets are gated by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'd0;
            end
        end else if (ctr_we) begin
            btb_ctr[up_idx] <= ctr_nxt;
            if (alloc) btb_valid[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tgt_we) btb_target[up_idx] <= actual_next;
        if (alloc)  btb_tag[up_idx]    <= up_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else begin
            if (redirect)      pc <= redirect_pc;
            else if (if_ready) pc <= pred_target;
            if (upd)      branch_cnt  <= branch_cnt + 32'd1;
            if (redirect) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_040066_bpu_nxtpc.sv
// Bench for ysyx_040066_bpu_nxtpc: directed sequences, a branch-code vector
// table and random traffic, all checked against an arithmetic BTB model.
module tb_ysyx_040066_bpu_nxtpc;

    localparam int          N        = 4;
    localparam int          IDX      = 2;
    localparam logic [63:0] RST_PC   = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_ready;
    logic [63:0] pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic [63:0] ex_busA;
    logic [63:0] ex_imm;
    logic        ex_zero;
    logic        ex_result0;
    logic [2:0]  ex_branch;
    logic        is_jmp;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_vec = 0;
    int n_err = 0;

    ysyx_040066_bpu_nxtpc #(.XLEN(64), .BTB_ENTRIES(N), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_busA(ex_busA), .ex_imm(ex_imm),
        .ex_zero(ex_zero), .ex_result0(ex_result0), .ex_branch(ex_branch),
        .is_jmp(is_jmp), .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic        m_valid [N];
    logic [63:0] m_tag   [N];
    logic [63:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [63:0] m_pc;
    logic [31:0] m_bcnt, m_mcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_pc   = RST_PC;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    function automatic int midx(input logic [63:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [63:0] mtag(input logic [63:0] a);
        return a / (4 * N);
    endfunction

    function automatic logic m_taken();
        case (ex_branch)
            3'd0:           return 1'b0;
            3'd1,3'd2,3'd3: return 1'b1;
            3'd4:           return ex_zero;
            3'd5:           return !ex_zero;
            3'd6:           return ex_result0;
            default:        return ex_zero || !ex_result0;
        endcase
    endfunction

    function automatic logic [63:0] m_actual();
        logic [63:0] s;
        s = ((ex_branch == 3'd2) ? ex_busA : ex_pc) + (m_taken() ? ex_imm : 64'd4);
        if (ex_branch == 3'd2) s = s & ~64'd1;
        return s;
    endfunction

    task automatic m_lookup(input logic [63:0] a, output logic t, output logic [63:0] tg);
        int i;
        i  = midx(a);
        t  = m_valid[i] && (m_tag[i] == mtag(a)) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : a + 64'd4;
    endtask

    task automatic drive(input logic v, input logic [2:0] br, input logic z, input logic r0,
                         input logic [63:0] epc, input logic [63:0] ba, input logic [63:0] im,
                         input logic [63:0] ptgt);
        ex_valid = v; ex_branch = br; ex_zero = z; ex_result0 = r0;
        ex_pc = epc; ex_busA = ba; ex_imm = im; ex_pred_target = ptgt;
        ex_pred_taken = (ptgt != epc + 64'd4);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    endtask

    // Let combinational outputs settle and compare them with the model.
    task automatic settle();
        logic        t;
        logic [63:0] tg;
        #1;
        m_lookup(m_pc, t, tg);
        check("pc", pc, m_pc);
        check("pred_taken", pred_taken, t);
        check("pred_target", pred_target, tg);
        check("is_jmp", is_jmp, ex_valid && m_taken());
        check("redirect", redirect, ex_valid && (m_actual() != ex_pred_target));
        check("redirect_pc", redirect_pc, m_actual());
    endtask

    // Advance the model across one clock edge, then the DUT, then compare counters.
    task automatic tick();
        logic        t, red, jump, hit;
        logic [63:0] tg, act;
        int          i;
        m_lookup(m_pc, t, tg);
        act = m_actual();
        red = ex_valid && (act != ex_pred_target);
        if (red)           m_pc = act;
        else if (if_ready) m_pc = tg;
        if (red) m_mcnt++;
        if (ex_valid && ex_branch != 3'd0) begin
            m_bcnt++;
            i    = midx(ex_pc);
            hit  = m_valid[i] && (m_tag[i] == mtag(ex_pc));
            jump = (ex_branch >= 3'd1) && (ex_branch <= 3'd3);
            if (hit) begin
                if (jump) begin
                    m_ctr[i] = 3; m_tgt[i] = act;
                end else if (m_taken()) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = act;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (m_taken()) begin
                m_valid[i] = 1'b1; m_tag[i] = mtag(ex_pc); m_tgt[i] = act;
                m_ctr[i] = jump ? 3 : 2;
            end
        end
        @(posedge clk);
        #1;
        check("branch_cnt", branch_cnt, m_bcnt);
        check("mispred_cnt", mispred_cnt, m_mcnt);
    endtask

    // Force the fetch PC to a chosen address through a mispredicted no-op.
    task automatic redirect_to(input logic [63:0] target);
        drive(1'b1, 3'd0, 1'b0, 1'b0, target - 64'd4, 64'd0, 64'd0, 64'd0);
        settle();
        tick();
        idle();
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  br;
        logic        z;
        logic        r0;
        logic [63:0] epc;
        logic [63:0] ba;
        logic [63:0] im;
        logic [63:0] ptgt;
        logic        e_jmp;
        logic        e_red;
        logic [63:0] e_rpc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 3'd0, 1'b1, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b0, 1'b0, 64'h8000_0204};
        tbl[1]  = '{1'b1, 3'd1, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0220};
        tbl[2]  = '{1'b1, 3'd2, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0320};
        tbl[3]  = '{1'b1, 3'd3, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0220};
        tbl[4]  = '{1'b1, 3'd4, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b0, 1'b0, 64'h8000_0204};
        tbl[5]  = '{1'b1, 3'd5, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0220};
        tbl[6]  = '{1'b1, 3'd6, 1'b0, 1'b1, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0220};
        tbl[7]  = '{1'b1, 3'd6, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b0, 1'b0, 64'h8000_0204};
        tbl[8]  = '{1'b1, 3'd7, 1'b0, 1'b1, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b0, 1'b0, 64'h8000_0204};
        tbl[9]  = '{1'b1, 3'd7, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0220};
        tbl[10] = '{1'b1, 3'd7, 1'b1, 1'b1, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0220};
        tbl[11] = '{1'b0, 3'd4, 1'b1, 1'b0, 64'h8000_0200, 64'h8000_0301, 64'h20, 64'h8000_0204, 1'b0, 1'b0, 64'h8000_0220};
        tbl[12] = '{1'b1, 3'd3, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h20, 64'h8000_0000, 1'b1, 1'b1, 64'h10};

        // Reset and sequential fetch
        rst_n = 1'b0; if_ready = 1'b0; idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        if_ready = 1'b1;
        check("reset pc", pc, RST_PC);
        check("reset branch_cnt", branch_cnt, 32'd0);
        check("reset mispred_cnt", mispred_cnt, 32'd0);
        check("reset redirect", redirect, 1'b0);
        check("reset is_jmp", is_jmp, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
            check("seq pc", pc, RST_PC + 64'(4 * (k + 1)));
        end

        // Taken beq allocates with ctr=2
        drive(1'b1, 3'd4, 1'b1, 1'b0, 64'h8000_0010, 64'd0, 64'h40, 64'h8000_0014);
        settle();
        check("beq redirect", redirect, 1'b1);
        check("beq redirect_pc", redirect_pc, 64'h8000_0050);
        check("beq is_jmp", is_jmp, 1'b1);
        tick();
        check("beq pc", pc, 64'h8000_0050);
        check("beq mispred_cnt", mispred_cnt, 32'd1);
        idle();
        redirect_to(64'h8000_0010);
        settle();
        check("beq pred_taken", pred_taken, 1'b1);
        check("beq pred_target", pred_target, 64'h8000_0050);

        // Two not-taken resolutions: ctr 2 -> 1 -> 0
        drive(1'b1, 3'd4, 1'b0, 1'b0, 64'h8000_0010, 64'd0, 64'h40, 64'h8000_0050);
        settle();
        check("nt1 redirect", redirect, 1'b1);
        check("nt1 redirect_pc", redirect_pc, 64'h8000_0014);
        check("nt1 is_jmp", is_jmp, 1'b0);
        tick();
        drive(1'b1, 3'd4, 1'b0, 1'b0, 64'h8000_0010, 64'd0, 64'h40, 64'h8000_0014);
        settle();
        check("nt2 redirect", redirect, 1'b0);
        tick();
        idle();
        redirect_to(64'h8000_0010);
        settle();
        check("nt pred_taken", pred_taken, 1'b0);
        check("nt pred_target", pred_target, 64'h8000_0014);

        // jalr clears bit 0 and allocates with ctr=3
        drive(1'b1, 3'd2, 1'b0, 1'b0, 64'h8000_0020, 64'h8000_1001, 64'd2, 64'h8000_0024);
        settle();
        check("jalr redirect_pc", redirect_pc, 64'h8000_1002);
        check("jalr redirect", redirect, 1'b1);
        tick();
        idle();
        redirect_to(64'h8000_0020);
        settle();
        check("jalr pred_taken", pred_taken, 1'b1);
        check("jalr pred_target", pred_target, 64'h8000_1002);

        // Redirect beats a stalled IF; async reset in the middle of a redirect
        if_ready = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 1'b0, 64'h8000_0100, 64'd0, 64'd0, 64'd0);
        settle();
        tick();
        check("stall redirect pc", pc, 64'h8000_0104);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 64'h8000_0200, 64'd0, 64'd0, 64'd0);
        settle();
        check("pre-reset redirect", redirect, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("async reset pc", pc, RST_PC);
        check("async reset branch_cnt", branch_cnt, 32'd0);
        check("async reset mispred_cnt", mispred_cnt, 32'd0);
        idle();
        #1;
        check("reset idle redirect", redirect, 1'b0);
        check("reset idle is_jmp", is_jmp, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        if_ready = 1'b1;
        redirect_to(64'h8000_0020);
        settle();
        check("post-reset btb invalid", pred_taken, 1'b0);

        // Aliasing: same index, second allocation evicts the first
        drive(1'b1, 3'd4, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'h100, 64'h8000_0004);
        settle();
        tick();
        drive(1'b1, 3'd4, 1'b1, 1'b0, 64'h8000_0010, 64'd0, 64'h100, 64'h8000_0014);
        settle();
        tick();
        idle();
        redirect_to(64'h8000_0000);
        settle();
        check("alias evicted", pred_taken, 1'b0);

        // Branch-code table
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].v, tbl[k].br, tbl[k].z, tbl[k].r0, tbl[k].epc, tbl[k].ba, tbl[k].im, tbl[k].ptgt);
            settle();
            check($sformatf("tbl%0d is_jmp", k), is_jmp, tbl[k].e_jmp);
            check($sformatf("tbl%0d redirect", k), redirect, tbl[k].e_red);
            check($sformatf("tbl%0d redirect_pc", k), redirect_pc, tbl[k].e_rpc);
            tick();
        end
        idle();

        // Random traffic over a small PC pool so entries hit, train and alias
        for (int k = 0; k < 1500; k++) begin
            logic        t;
            logic [63:0] tg;
            int          sel;
            if_ready   = ($urandom_range(0, 3) != 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_branch  = 3'($urandom_range(0, 7));
            ex_zero    = 1'($urandom_range(0, 1));
            ex_result0 = 1'($urandom_range(0, 1));
            ex_pc      = 64'h8000_0000 + 64'(4 * $urandom_range(0, 15));
            ex_busA    = {$urandom, $urandom};
            ex_imm     = 64'(4 * $urandom_range(0, 63));
            ex_pred_taken = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            m_lookup(ex_pc, t, tg);
            if (sel == 0)      ex_pred_target = m_actual();
            else if (sel == 1) ex_pred_target = ex_pc + 64'd4;
            else               ex_pred_target = tg;
            settle();
            tick();
        end
        idle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
